// File: rtl/corner_addr_buffer.sv
// Stores FAST9 corner addresses in arrival order and presents a frozen snapshot to the matcher.
// Latency: rd_req to o_out_valid is 1 cycle. The snapshot is held until o_out_ready, and writes stall until then.
module corner_addr_buffer #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1),
  parameter int DROP_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_wr_en,
  input  logic [ADDR_W-1:0]       i_wr_addr,
  output logic                    o_wr_ready,
  input  logic                    i_rd_req,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [ADDR_W*DEPTH-1:0] o_position,
  output logic [DEPTH-1:0]        o_valid_mask,
  output logic [CNT_W-1:0]        o_out_count,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_full,
  output logic                    o_overflow,
  output logic [DROP_W-1:0]       o_drop_cnt
);

  typedef enum logic {S_FILL = 1'b0, S_READ = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_W-1:0]       r_entry [DEPTH];
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    r_overflow;
  logic [DROP_W-1:0]       r_drop_cnt;
  logic [ADDR_W*DEPTH-1:0] r_position;
  logic [ADDR_W*DEPTH-1:0] w_position;
  logic [DEPTH-1:0]        r_valid_mask;
  logic [DEPTH-1:0]        w_valid_mask;
  logic [CNT_W-1:0]        r_out_count;
  logic                    w_full;
  logic                    w_wr_ready;
  logic                    w_wr_acc;
  logic                    w_wr_drop;
  logic                    w_snap;
  logic                    w_hs;

  assign w_full = (r_count == CNT_W'(DEPTH));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = S_FILL;
    end else begin
      case (r_state)
        S_FILL:  if (i_rd_req) w_state_nxt = S_READ;
        S_READ:  if (i_out_ready) w_state_nxt = S_FILL;
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  always_comb begin
    w_wr_ready = (r_state == S_FILL) && !w_full;
    w_wr_acc   = i_wr_en && w_wr_ready && !i_clear;
    w_wr_drop  = i_wr_en && (r_state == S_FILL) && w_full && !i_clear;
    w_snap     = (r_state == S_FILL) && i_rd_req && !i_clear;
    w_hs       = (r_state == S_READ) && i_out_ready && !i_clear;
  end

  // The snapshot includes a write accepted on the same edge; slots past the fill level read as zero.
  always_comb begin
    w_count_nxt  = r_count + CNT_W'(w_wr_acc);
    w_position   = '0;
    w_valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count)
        w_position[ADDR_W*(DEPTH-i)-1 -: ADDR_W] = r_entry[i];
      else if (w_wr_acc && (CNT_W'(i) == r_count))
        w_position[ADDR_W*(DEPTH-i)-1 -: ADDR_W] = i_wr_addr;
      w_valid_mask[DEPTH-1-i] = (CNT_W'(i) < w_count_nxt);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
      r_position   <= '0;
      r_valid_mask <= '0;
      r_out_count  <= '0;
    end else if (i_clear) begin
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
      r_position   <= '0;
      r_valid_mask <= '0;
      r_out_count  <= '0;
    end else if (w_hs) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_wr_acc && (r_count == CNT_W'(i))) r_entry[i] <= i_wr_addr;
      r_count <= w_count_nxt;
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {DROP_W{1'b1}}) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
      if (w_snap) begin
        r_position   <= w_position;
        r_valid_mask <= w_valid_mask;
        r_out_count  <= w_count_nxt;
      end
    end
  end

  assign o_wr_ready   = w_wr_ready;
  assign o_out_valid  = (r_state == S_READ);
  assign o_position   = r_position;
  assign o_valid_mask = r_valid_mask;
  assign o_out_count  = r_out_count;
  assign o_count      = r_count;
  assign o_full       = w_full;
  assign o_overflow   = r_overflow;
  assign o_drop_cnt   = r_drop_cnt;

endmodule
